ps2_scan_rx: RTL

PS2_SCAN_RX -- requirements
Module: ps2_scan_rx

---
 rtl/ps2_scan_rx.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: synchronizes and filters the PS/2 lines, deframes bytes and
// tracks make/break/extended prefixes to present the currently held scancode.
module ps2_scan_rx #(
   parameter int unsigned FILT_LEN = 8,
   parameter int unsigned TIMEOUT  = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] code,
   output logic       code_valid,
   output logic       code_ext,
   output logic [7:0] raw,
   output logic       raw_valid,
   output logic       frame_err
);

   localparam int unsigned FW = $clog2(FILT_LEN + 1);
   localparam int unsigned WW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

   // Index 0 carries ps2_clk, index 1 carries ps2_data.
   logic [1:0]    s1_q, s2_q, f_q;
   logic [FW-1:0] fc_q [2];
   logic          fclk_prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q        <= '1;
         s2_q        <= '1;
         f_q         <= '1;
         fclk_prev_q <= 1'b1;
         for (int i = 0; i < 2; i++) fc_q[i] <= '0;
      end else begin
         s1_q        <= {ps2_data, ps2_clk};
         s2_q        <= s1_q;
         fclk_prev_q <= f_q[0];
         for (int i = 0; i < 2; i++) begin
            if (s2_q[i] == f_q[i]) begin
               fc_q[i] <= '0;
            end else if (fc_q[i] == FW'(FILT_LEN - 1)) begin
               f_q[i]  <= s2_q[i];
               fc_q[i] <= '0;
            end else begin
               fc_q[i] <= fc_q[i] + 1'b1;
            end
         end
      end
   end

   logic ev, bit_in;
   assign ev     = fclk_prev_q & ~f_q[0];
   assign bit_in = f_q[1];

   state_e        state_q, state_d;
   logic [2:0]    bitcnt_q, bitcnt_d;
   logic [7:0]    sh_q, sh_d;
   logic          perr_q, perr_d;
   logic [WW-1:0] wd_q, wd_d;
   logic          brk_q, brk_d, ext_q, ext_d;
   logic [7:0]    code_q, code_d, raw_q, raw_d;
   logic          code_ext_q, code_ext_d;
   logic          code_valid_q, code_valid_d, raw_valid_q, raw_valid_d;
   logic          frame_err_q, frame_err_d;
   logic          accept, fail;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         bitcnt_q     <= '0;
         sh_q         <= '0;
         perr_q       <= 1'b0;
         wd_q         <= '0;
         brk_q        <= 1'b0;
         ext_q        <= 1'b0;
         code_q       <= '0;
         raw_q        <= '0;
         code_ext_q   <= 1'b0;
         code_valid_q <= 1'b0;
         raw_valid_q  <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         bitcnt_q     <= bitcnt_d;
         sh_q         <= sh_d;
         perr_q       <= perr_d;
         wd_q         <= wd_d;
         brk_q        <= brk_d;
         ext_q        <= ext_d;
         code_q       <= code_d;
         raw_q        <= raw_d;
         code_ext_q   <= code_ext_d;
         code_valid_q <= code_valid_d;
         raw_valid_q  <= raw_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      bitcnt_d     = bitcnt_q;
      sh_d         = sh_q;
      perr_d       = perr_q;
      wd_d         = wd_q;
      brk_d        = brk_q;
      ext_d        = ext_q;
      code_d       = code_q;
      raw_d        = raw_q;
      code_ext_d   = code_ext_q;
      code_valid_d = 1'b0;
      raw_valid_d  = 1'b0;
      frame_err_d  = 1'b0;
      accept       = 1'b0;
      fail         = 1'b0;

      unique case (state_q)
         StIdle: begin
            wd_d = '0;
            if (ev && !bit_in) begin
               state_d  = StData;
               bitcnt_d = '0;
            end
         end
         StData: begin
            if (ev) begin
               sh_d     = {bit_in, sh_q[7:1]};
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) state_d = StParity;
            end
         end
         StParity: begin
            if (ev) begin
               perr_d  = ~(^{bit_in, sh_q});
               state_d = StStop;
            end
         end
         StStop: begin
            if (ev) begin
               state_d = StIdle;
               if (bit_in && !perr_q) accept = 1'b1;
               else                   fail   = 1'b1;
            end
         end
      endcase

      // Watchdog only runs inside a frame; expiry abandons the partial byte.
      if (state_q != StIdle) begin
         if (ev) begin
            wd_d = '0;
         end else if (wd_q == WW'(TIMEOUT - 1)) begin
            wd_d    = '0;
            state_d = StIdle;
            fail    = 1'b1;
         end else begin
            wd_d = wd_q + 1'b1;
         end
      end

      if (fail) begin
         frame_err_d = 1'b1;
         brk_d       = 1'b0;
         ext_d       = 1'b0;
      end

      if (accept) begin
         raw_d       = sh_q;
         raw_valid_d = 1'b1;
         if (sh_q == 8'hF0) begin
            brk_d = 1'b1;
         end else if (sh_q == 8'hE0) begin
            ext_d = 1'b1;
         end else begin
            if (brk_q) begin
               if (sh_q == code_q) begin
                  code_d     = 8'h00;
                  code_ext_d = 1'b0;
               end
            end else begin
               code_d       = sh_q;
               code_ext_d   = ext_q;
               code_valid_d = 1'b1;
            end
            brk_d = 1'b0;
            ext_d = 1'b0;
         end
      end
   end

   assign code       = code_q;
   assign code_valid = code_valid_q;
   assign code_ext   = code_ext_q;
   assign raw        = raw_q;
   assign raw_valid  = raw_valid_q;
   assign frame_err  = frame_err_q;

endmodule
